led_pattern_seq: RTL and testbench

- Downstream consumer of the free-running blink divider.
- Takes the divider's one-cycle wrap pulse (`tick`) and drives the board LED from a configurable mode: off, solid, toggling, or a programmable bit pattern played a set number of times.
- Configuration arrives over a valid/ready handshake from the control block.
- Sits between the blink divider and the LED pad.

---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_pat_player.sv | 83 ++++++++
 rtl/led_pattern_seq.sv | 109 ++++++++++
 tb/tb_led_pattern_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_seq_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned REP_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_PATTERN = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit-index width; a 1-bit pattern still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pat_player.sv
// Plays a latched bit pattern one bit per tick, repeating it rep extra times.
module led_pat_player
    import led_seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] rep,
    output logic             pat_bit_c,
    output logic             finish_c,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = idx_width(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Player state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= '0;
            idx_q  <= '0;
            rep_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            idx_q  <= idx_d;
            rep_q  <= rep_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next bit is exposed combinationally so the top can register it straight into led.
    always_comb begin
        pat_d     = pat_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        finish_c  = 1'b0;
        pat_bit_c = pat_q[idx_q] & busy_q;

        if (load) begin
            pat_d     = pattern;
            rep_d     = rep;
            idx_d     = '0;
            busy_d    = 1'b1;
            pat_bit_c = pattern[0];
        end else if (tick && busy_q) begin
            if (idx_q != IDX_LAST) begin
                idx_d     = idx_q + IDX_W'(1);
                pat_bit_c = pat_q[idx_d];
            end else if (rep_q != '0) begin
                rep_d     = rep_q - REP_W'(1);
                idx_d     = '0;
                pat_bit_c = pat_q[0];
            end else begin
                idx_d     = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                finish_c  = 1'b1;
                pat_bit_c = 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED driver: OFF/ON/BLINK/PATTERN modes loaded over a valid/ready handshake, advanced by tick.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             led,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;
    mode_e  mode_q, mode_d;
    logic   led_q, led_d;
    logic   xfer_c;
    logic   pat_load_c;
    logic   pat_bit_c;
    logic   pat_finish_c;

    // A running pattern cannot be preempted; every other mode accepts a new word.
    assign cfg_ready = (state_q == ST_IDLE) || (mode_q != MODE_PATTERN);
    assign xfer_c    = cfg_valid && cfg_ready;

    led_pat_player #(
        .PAT_W (PAT_W),
        .REP_W (REP_W)
    ) u_player (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pat_load_c),
        .tick      (tick),
        .pattern   (cfg_pattern),
        .rep       (cfg_repeat),
        .pat_bit_c (pat_bit_c),
        .finish_c  (pat_finish_c),
        .busy      (busy),
        .done      (done)
    );

    // FSM, mode and LED registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    // A transfer takes priority over a coincident tick, which is dropped.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        led_d      = led_q;
        pat_load_c = 1'b0;

        if (xfer_c) begin
            mode_d = mode_e'(cfg_mode);
            case (mode_e'(cfg_mode))
                MODE_OFF: begin
                    state_d = ST_IDLE;
                    led_d   = 1'b0;
                end
                MODE_ON, MODE_BLINK: begin
                    state_d = ST_RUN;
                    led_d   = 1'b1;
                end
                default: begin
                    state_d    = ST_RUN;
                    pat_load_c = 1'b1;
                    led_d      = pat_bit_c;
                end
            endcase
        end else if (state_q == ST_RUN) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (tick) begin
                        led_d = ~led_q;
                    end
                end
                MODE_PATTERN: begin
                    led_d = pat_bit_c;
                    if (pat_finish_c) begin
                        state_d = ST_IDLE;
                        mode_d  = MODE_OFF;
                    end
                end
                default: begin
                    led_d = led_q;
                end
            endcase
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: stimulus table plus reset corner cases.
module tb_led_pattern_seq;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_repeat;
    logic       led;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       tk;
        logic       vld;
        logic [1:0] mode;
        logic [7:0] pat;
        logic [3:0] rep;
        logic       e_led;
        logic       e_busy;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    // Run-length monitor: ticks between each PATTERN handshake and its done pulse.
    logic armed = 1'b0;
    int   run_ticks = 0;
    int   runs[$];

    led_pattern_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_pattern (cfg_pattern),
        .cfg_repeat  (cfg_repeat),
        .led         (led),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            if (armed && tick) run_ticks <= run_ticks + 1;
            if (done && armed) begin
                runs.push_back(run_ticks);
                armed <= 1'b0;
            end
            if (cfg_valid && cfg_ready && cfg_mode == 2'd3) begin
                armed     <= 1'b1;
                run_ticks <= 0;
            end
        end
    end

    task automatic add(input logic tk, input logic vld, input logic [1:0] m,
                       input logic [7:0] p, input logic [3:0] r,
                       input logic el, input logic eb, input logic ed, input logic er);
        vec_t v;
        v.tk = tk; v.vld = vld; v.mode = m; v.pat = p; v.rep = r;
        v.e_led = el; v.e_busy = eb; v.e_done = ed; v.e_rdy = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic tk, input logic vld, input logic [1:0] m,
                        input logic [7:0] p, input logic [3:0] r);
        tick = tk; cfg_valid = vld; cfg_mode = m; cfg_pattern = p; cfg_repeat = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic el, input logic eb,
                           input logic ed, input logic er);
        chk({tag, " led"}, led, el);
        chk({tag, " busy"}, busy, eb);
        chk({tag, " done"}, done, ed);
        chk({tag, " ready"}, cfg_ready, er);
    endtask

    initial begin
        logic       eled;
        logic [7:0] p;

        rst_n = 1'b0; tick = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 2'd0; cfg_pattern = 8'h00; cfg_repeat = 4'd0;

        // Reset held with tick toggling, then released with no transfer.
        for (int i = 0; i < 3; i++) begin
            tick = ~tick;
            @(posedge clk);
            #1;
            chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 2'd0, 8'h00, 4'd0);
            chk_all($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // BLINK: load, then 4 ticks spaced 5 cycles apart.
        add(0, 1, 2'd2, 8'h00, 4'd0, 1, 0, 0, 1);
        eled = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) add(0, 0, 2'd0, 8'h00, 4'd0, eled, 0, 0, 1);
            eled = ~eled;
            add(1, 0, 2'd0, 8'h00, 4'd0, eled, 0, 0, 1);
        end
        // Collisions: reloading BLINK with a tick must not toggle; ON ignores ticks; OFF idles.
        add(1, 0, 2'd0, 8'h00, 4'd0, 0, 0, 0, 1);
        add(1, 1, 2'd2, 8'h00, 4'd0, 1, 0, 0, 1);
        add(1, 1, 2'd1, 8'h00, 4'd0, 1, 0, 0, 1);
        add(1, 0, 2'd0, 8'h00, 4'd0, 1, 0, 0, 1);
        add(0, 1, 2'd0, 8'h00, 4'd0, 0, 0, 0, 1);
        add(1, 0, 2'd0, 8'h00, 4'd0, 0, 0, 0, 1);

        // PATTERN once, ticks every 3 cycles, rival offers held off in between.
        p = 8'b1011_0010;
        add(0, 1, 2'd3, p, 4'd0, p[0], 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 2; j++)
                add(0, 1, 2'd3, 8'hFF, 4'd0, p[k-1], 1, 0, 0);
            if (k < 8) add(1, 0, 2'd0, 8'h00, 4'd0, p[k], 1, 0, 0);
            else       add(1, 0, 2'd0, 8'h00, 4'd0, 0, 0, 1, 1);
        end
        add(0, 0, 2'd0, 8'h00, 4'd0, 0, 0, 0, 1);

        // PATTERN 8'h01 with repeat 2: 24 ticks, ON offers during the run are refused.
        add(0, 1, 2'd3, 8'h01, 4'd2, 1, 1, 0, 0);
        for (int t = 1; t <= 24; t++) begin
            if (t < 24) add(1, t % 2, 2'd1, 8'h00, 4'd0, (t % 8) == 0, 1, 0, 0);
            else        add(1, 0, 2'd0, 8'h00, 4'd0, 0, 0, 1, 1);
        end
        // New load in the cycle right after done.
        add(0, 1, 2'd3, 8'h80, 4'd0, 0, 1, 0, 0);
        for (int t = 1; t <= 8; t++) begin
            if (t < 8) add(1, 0, 2'd0, 8'h00, 4'd0, t == 7, 1, 0, 0);
            else       add(1, 0, 2'd0, 8'h00, 4'd0, 0, 0, 1, 1);
        end
        add(0, 0, 2'd0, 8'h00, 4'd0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].tk, tbl[i].vld, tbl[i].mode, tbl[i].pat, tbl[i].rep);
            chk_all($sformatf("row%0d", i), tbl[i].e_led, tbl[i].e_busy,
                    tbl[i].e_done, tbl[i].e_rdy);
        end

        // Mid-run reset at tick 5 of a PATTERN run.
        step(0, 1, 2'd3, 8'h10, 4'd1);
        chk_all("mr_load", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) step(1, 0, 2'd0, 8'h00, 4'd0);
        chk_all("mr_tick4", 1'b1, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all("mr_async", 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        tick = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'd0, 8'h00, 4'd0);
            chk_all($sformatf("mr_after%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(0, 1, 2'd3, 8'h01, 4'd0);
        chk_all("mr_reload", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 8; t++) begin
            step(1, 0, 2'd0, 8'h00, 4'd0);
            if (t < 8) chk_all($sformatf("mr_t%0d", t), 1'b0, 1'b1, 1'b0, 1'b0);
            else       chk_all("mr_done", 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step(0, 0, 2'd0, 8'h00, 4'd0);

        // Every PATTERN load must have reached done after PAT_W*(repeat+1) ticks.
        chk_int("run_count", runs.size(), 4);
        if (runs.size() == 4) begin
            chk_int("run0_len", runs[0], 8);
            chk_int("run1_len", runs[1], 24);
            chk_int("run2_len", runs[2], 8);
            chk_int("run3_len", runs[3], 8);
        end
        chk("no_pending_run", armed, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
